// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: oversampling UART receiver (8N1, or 8E1 when UART_RX_PARITY_EN
// is defined) feeding a first-word fall-through byte FIFO.
//
// Configuration macro: UART_RX_PARITY_EN adds a PARITY state and the
// parity_err output.
//
// Ports:
//   clk_50m     system clock, rising edge
//   rst_n       asynchronous active-low reset
//   rxd         serial line, asynchronous, idles high
//   rd_en       pop request, honoured only while rx_rdy=1
//   rd_data     FIFO head byte (valid while rx_rdy=1)
//   rx_rdy      FIFO not empty
//   fifo_cnt    FIFO occupancy, 0..2**DEPTH_LOG2
//   frame_err   sticky, stop bit sampled low
//   overrun     sticky, byte dropped on a full FIFO
//   parity_err  sticky, parity mismatch (UART_RX_PARITY_EN only)
//   clr_err     synchronous clear of the sticky flags; a coincident set wins
module uart_rx_fifo #(
  parameter int unsigned CLK_HZ     = 50000000,
  parameter int unsigned BAUD       = 115200,
  parameter int unsigned DEPTH_LOG2 = 4
) (
  input  logic                  clk_50m,
  input  logic                  rst_n,
  input  logic                  rxd,
  input  logic                  rd_en,
  output logic [7:0]            rd_data,
  output logic                  rx_rdy,
  output logic [DEPTH_LOG2:0]   fifo_cnt,
  output logic                  frame_err,
  output logic                  overrun,
`ifdef UART_RX_PARITY_EN
  output logic                  parity_err,
`endif
  input  logic                  clr_err
);

  localparam int unsigned CLKS_PER_BIT = CLK_HZ / BAUD;
  localparam int unsigned HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int unsigned CNT_W        = $clog2(CLKS_PER_BIT);
  localparam int unsigned DEPTH        = 2 ** DEPTH_LOG2;
  localparam int unsigned CW           = DEPTH_LOG2 + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_RX_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_t;

  state_t                state;
  logic                  rxd_m;
  logic                  rxd_s;
  logic                  rxd_s_d;
  logic [CNT_W-1:0]      baud_cnt;
  logic [2:0]            bit_idx;
  logic [7:0]            shreg;
  logic                  push_vld;
  logic [7:0]            push_byte;
`ifdef UART_RX_PARITY_EN
  logic                  par_ok;
`endif

  logic [7:0]            mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;

  logic                  push_ok_c;
  logic                  pop_ok_c;
  logic [DEPTH_LOG2-1:0] rd_ptr_nxt_c;
  logic [CW-1:0]         cnt_nxt_c;
  logic [7:0]            head_c;

  wire mid_start = (baud_cnt == CNT_W'(HALF_BIT - 1));
  wire bit_end   = (baud_cnt == CNT_W'(CLKS_PER_BIT - 1));

  // Two-flop synchroniser plus one delay flop for falling-edge detection.
  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      rxd_m   <= 1'b1;
      rxd_s   <= 1'b1;
      rxd_s_d <= 1'b1;
    end else begin
      rxd_m   <= rxd;
      rxd_s   <= rxd_m;
      rxd_s_d <= rxd_s;
    end
  end

  // Receive FSM; emits a one-cycle push strobe with the assembled byte.
  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      baud_cnt   <= '0;
      bit_idx    <= '0;
      shreg      <= '0;
      push_vld   <= 1'b0;
      push_byte  <= '0;
      frame_err  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_ok     <= 1'b1;
      parity_err <= 1'b0;
`endif
    end else begin
      push_vld <= 1'b0;
      if (clr_err) begin
        frame_err  <= 1'b0;
`ifdef UART_RX_PARITY_EN
        parity_err <= 1'b0;
`endif
      end
      case (state)
        S_IDLE: begin
          if (rxd_s_d && !rxd_s) begin
            baud_cnt <= '0;
            state    <= S_START;
          end
        end
        S_START: begin
          if (mid_start) begin
            baud_cnt <= '0;
            bit_idx  <= '0;
            // A high line at mid start bit means the edge was a glitch.
            state    <= rxd_s ? S_IDLE : S_DATA;
          end else begin
            baud_cnt <= baud_cnt + CNT_W'(1);
          end
        end
        S_DATA: begin
          if (bit_end) begin
            shreg    <= {rxd_s, shreg[7:1]};
            baud_cnt <= '0;
            bit_idx  <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              state <= S_PARITY;
`else
              state <= S_STOP;
`endif
            end
          end else begin
            baud_cnt <= baud_cnt + CNT_W'(1);
          end
        end
`ifdef UART_RX_PARITY_EN
        S_PARITY: begin
          if (bit_end) begin
            // Even parity: data bits plus parity bit must XOR to zero.
            par_ok   <= ~(^{shreg, rxd_s});
            if (^{shreg, rxd_s}) parity_err <= 1'b1;
            baud_cnt <= '0;
            state    <= S_STOP;
          end else begin
            baud_cnt <= baud_cnt + CNT_W'(1);
          end
        end
`endif
        S_STOP: begin
          if (bit_end) begin
            baud_cnt  <= '0;
            push_byte <= shreg;
            state     <= S_IDLE;
            if (rxd_s) begin
`ifdef UART_RX_PARITY_EN
              push_vld <= par_ok;
`else
              push_vld <= 1'b1;
`endif
            end else begin
              frame_err <= 1'b1;
            end
          end else begin
            baud_cnt <= baud_cnt + CNT_W'(1);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // FIFO next-state: a push into a full FIFO is accepted only alongside a pop.
  always_comb begin
    pop_ok_c     = rd_en && rx_rdy;
    push_ok_c    = push_vld && ((fifo_cnt < CW'(DEPTH)) || rd_en);
    rd_ptr_nxt_c = pop_ok_c ? rd_ptr + DEPTH_LOG2'(1) : rd_ptr;
    cnt_nxt_c    = fifo_cnt;
    if (push_ok_c && !pop_ok_c) cnt_nxt_c = fifo_cnt + CW'(1);
    if (!push_ok_c && pop_ok_c) cnt_nxt_c = fifo_cnt - CW'(1);
    // Bypass covers the write landing on the slot that becomes the head.
    head_c = (push_ok_c && (wr_ptr == rd_ptr_nxt_c)) ? push_byte : mem[rd_ptr_nxt_c];
  end

  // FIFO storage.
  always_ff @(posedge clk_50m) begin
    if (push_ok_c) mem[wr_ptr] <= push_byte;
  end

  // FIFO pointers, occupancy, registered head and overrun flag.
  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
      rx_rdy   <= 1'b0;
      rd_data  <= '0;
      overrun  <= 1'b0;
    end else begin
      if (push_ok_c) wr_ptr <= wr_ptr + DEPTH_LOG2'(1);
      rd_ptr   <= rd_ptr_nxt_c;
      fifo_cnt <= cnt_nxt_c;
      rx_rdy   <= (cnt_nxt_c != '0);
      if (push_ok_c || pop_ok_c) rd_data <= head_c;
      if (clr_err) overrun <= 1'b0;
      if (push_vld && !push_ok_c) overrun <= 1'b1;
    end
  end

endmodule
